// File: rtl/operand_nibble_sequencer_pkg.sv
// Shared encodings and widths for the operand nibble sequencer.
// The state values are fixed so that status decode and debug probes agree across the board top.
package operand_nibble_sequencer_pkg;
    localparam int OP_W  = 32;
    localparam int NIB_W = 4;

    typedef enum logic [1:0] {
        ST_LOAD_A = 2'd0,
        ST_LOAD_B = 2'd1,
        ST_DONE   = 2'd2
    } state_t;
endpackage

// File: rtl/operand_nibble_sequencer.sv
// Assembles operands A and B MSB-nibble-first from debounced load pulses,
// in single (8 nibbles) or half (4 nibbles, upper 16 bits) format.
module operand_nibble_sequencer
    import operand_nibble_sequencer_pkg::*;
#(
    parameter int FULL_NIBBLES = 8,
    parameter int HALF_NIBBLES = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_pulse,
    input  logic              clear,
    input  logic              mode_fp,
    input  logic [NIB_W-1:0]  nibble_a,
    input  logic [NIB_W-1:0]  nibble_b,
    output logic [OP_W-1:0]   op_a,
    output logic [OP_W-1:0]   op_b,
    output logic              loading_a,
    output logic              loading_b,
    output logic              both_loaded,
    output logic [2:0]        nib_idx
);

    state_t     state, state_nxt;
    logic       mode_lat;
    logic [2:0] last_idx;
    logic       last_nib;
    logic [4:0] nib_hi;

    // 31 - 4*k for a 3-bit k, without any width juggling
    assign nib_hi   = {~nib_idx, 2'b11};
    assign last_idx = mode_lat ? 3'(FULL_NIBBLES - 1) : 3'(HALF_NIBBLES - 1);
    assign last_nib = (nib_idx == last_idx);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_LOAD_A: if (load_pulse && last_nib) state_nxt = ST_LOAD_B;
            ST_LOAD_B: if (load_pulse && last_nib) state_nxt = ST_DONE;
            ST_DONE:   if (load_pulse)             state_nxt = ST_LOAD_A;
            default:                               state_nxt = ST_LOAD_A;
        endcase
        if (clear) state_nxt = ST_LOAD_A;
    end

    // Status flags are registered from the next state so they change with state itself.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_LOAD_A;
            loading_a   <= 1'b1;
            loading_b   <= 1'b0;
            both_loaded <= 1'b0;
        end else begin
            state       <= state_nxt;
            loading_a   <= (state_nxt == ST_LOAD_A);
            loading_b   <= (state_nxt == ST_LOAD_B);
            both_loaded <= (state_nxt == ST_DONE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a     <= '0;
            op_b     <= '0;
            nib_idx  <= '0;
            mode_lat <= 1'b1;
        end else if (clear) begin
            op_a    <= '0;
            op_b    <= '0;
            nib_idx <= '0;
        end else if (load_pulse) begin
            case (state)
                ST_LOAD_A: begin
                    op_a[nib_hi -: NIB_W] <= nibble_a;
                    if (nib_idx == 3'd0) mode_lat <= mode_fp;
                    nib_idx <= last_nib ? 3'd0 : nib_idx + 3'd1;
                end
                ST_LOAD_B: begin
                    op_b[nib_hi -: NIB_W] <= nibble_b;
                    nib_idx <= last_nib ? 3'd0 : nib_idx + 3'd1;
                end
                ST_DONE: begin
                    // Restart: this pulse is already the first nibble of the new A.
                    op_a     <= {nibble_a, {(OP_W-NIB_W){1'b0}}};
                    op_b     <= '0;
                    mode_lat <= mode_fp;
                    nib_idx  <= 3'd1;
                end
                default: nib_idx <= 3'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_operand_nibble_sequencer.sv
// Randomized and directed checks of the nibble sequencer against a queue-based operand model.
module tb_operand_nibble_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load_pulse = 1'b0;
    logic        clear = 1'b0;
    logic        mode_fp = 1'b1;
    logic [3:0]  nibble_a = '0;
    logic [3:0]  nibble_b = '0;
    logic [31:0] op_a, op_b;
    logic        loading_a, loading_b, both_loaded;
    logic [2:0]  nib_idx;

    int n_cmp = 0;
    int n_err = 0;

    operand_nibble_sequencer dut (
        .clk(clk), .rst_n(rst_n), .load_pulse(load_pulse), .clear(clear), .mode_fp(mode_fp),
        .nibble_a(nibble_a), .nibble_b(nibble_b), .op_a(op_a), .op_b(op_b),
        .loading_a(loading_a), .loading_b(loading_b), .both_loaded(both_loaded), .nib_idx(nib_idx)
    );

    always #5 clk = ~clk;

    // Model: the nibbles accepted so far for each operand, plus the operand length.
    int qa[$];
    int qb[$];
    int n_len = 8;

    function automatic logic [31:0] build(input int q[$]);
        logic [31:0] v = 0;
        foreach (q[i]) v = v + (32'(q[i]) << (28 - 4 * i));
        return v;
    endfunction

    function automatic logic [69:0] exp_vec();
        logic la, lb, dn;
        logic [2:0] idx;
        la  = qa.size() < n_len;
        lb  = !la && qb.size() < n_len;
        dn  = !la && !lb;
        idx = la ? 3'(qa.size()) : lb ? 3'(qb.size()) : 3'd0;
        return {build(qa), build(qb), la, lb, dn, idx};
    endfunction

    function automatic logic [69:0] act_vec();
        return {op_a, op_b, loading_a, loading_b, both_loaded, nib_idx};
    endfunction

    task automatic model_reset();
        qa.delete(); qb.delete(); n_len = 8;
    endtask

    task automatic model_step(input logic lp, input logic clr, input int a, input int b, input logic mf);
        if (clr) begin
            qa.delete(); qb.delete();
        end else if (lp) begin
            if (qa.size() == n_len && qb.size() == n_len) begin
                qa.delete(); qb.delete();
                n_len = mf ? 8 : 4;
                qa.push_back(a);
            end else if (qa.size() < n_len) begin
                if (qa.size() == 0) n_len = mf ? 8 : 4;
                qa.push_back(a);
            end else begin
                qb.push_back(b);
            end
        end
    endtask

    // Drive one cycle of inputs from a negedge; returns at the following negedge.
    task automatic step(input logic lp, input logic clr, input logic [3:0] a, input logic [3:0] b, input logic mf);
        load_pulse = lp; clear = clr; nibble_a = a; nibble_b = b; mode_fp = mf;
        @(posedge clk);
        model_step(lp, clr, int'(a), int'(b), mf);
        @(negedge clk);
        load_pulse = 1'b0; clear = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk);
        model_reset();
        n_cmp++;
        if (act_vec() !== {32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 3'd0}) begin
            n_err++; $display("FAIL reset_hold: got %h want %h", act_vec(), {32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 3'd0});
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (act_vec() !== exp_vec()) begin
            n_err++; $display("FAIL reset_release: got %h want %h", act_vec(), exp_vec());
        end
    endtask

    task automatic test_full();
        logic [3:0] na [8] = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8};
        logic [3:0] nb [8] = '{4'hC, 4'h0, 4'hA, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b0, na[i], 4'h0, 1'b1);
            n_cmp++;
            if (act_vec() !== exp_vec()) begin
                n_err++; $display("FAIL full_a[%0d]: got %h want %h", i, act_vec(), exp_vec());
            end
        end
        n_cmp++;
        if (op_a !== 32'h12345678 || loading_b !== 1'b1) begin
            n_err++; $display("FAIL full_a_value: got %h/%b want 12345678/1", op_a, loading_b);
        end
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b0, 4'hF, nb[i], 1'b1);
            n_cmp++;
            if (act_vec() !== exp_vec()) begin
                n_err++; $display("FAIL full_b[%0d]: got %h want %h", i, act_vec(), exp_vec());
            end
        end
        n_cmp++;
        if (op_b !== 32'hC0A00000 || both_loaded !== 1'b1) begin
            n_err++; $display("FAIL full_b_value: got %h/%b want c0a00000/1", op_b, both_loaded);
        end
        step(1'b0, 1'b0, 4'h0, 4'h0, 1'b0);
        n_cmp++;
        if (act_vec() !== exp_vec()) begin
            n_err++; $display("FAIL done_hold: got %h want %h", act_vec(), exp_vec());
        end
    endtask

    task automatic test_done_reload();
        step(1'b1, 1'b0, 4'h9, 4'h0, 1'b1);
        n_cmp++;
        if (act_vec() !== {32'h90000000, 32'h0, 1'b1, 1'b0, 1'b0, 3'd1}) begin
            n_err++; $display("FAIL done_reload: got %h want %h", act_vec(), {32'h90000000, 32'h0, 1'b1, 1'b0, 1'b0, 3'd1});
        end
        n_cmp++;
        if (act_vec() !== exp_vec()) begin
            n_err++; $display("FAIL done_reload_model: got %h want %h", act_vec(), exp_vec());
        end
        step(1'b0, 1'b1, 4'h0, 4'h0, 1'b1);
    endtask

    task automatic test_half();
        logic [3:0] na [4] = '{4'h3, 4'hC, 4'h0, 4'h0};
        logic [3:0] nb [4] = '{4'h4, 4'h0, 4'h0, 4'h0};
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b0, i < 4 ? na[i] : 4'h5, i < 4 ? 4'h6 : nb[i-4], 1'b0);
            n_cmp++;
            if (act_vec() !== exp_vec()) begin
                n_err++; $display("FAIL half[%0d]: got %h want %h", i, act_vec(), exp_vec());
            end
        end
        n_cmp++;
        if (op_a !== 32'h3C000000 || op_b !== 32'h40000000 || both_loaded !== 1'b1) begin
            n_err++; $display("FAIL half_value: got %h %h %b want 3c000000 40000000 1", op_a, op_b, both_loaded);
        end
    endtask

    task automatic test_mode_toggle();
        int pulses = 0;
        step(1'b1, 1'b0, 4'hA, 4'h0, 1'b1);
        pulses++;
        while (both_loaded !== 1'b1 && pulses < 40) begin
            step(1'b1, 1'b0, 4'(pulses), 4'(pulses + 3), pulses < 2);
            pulses++;
            n_cmp++;
            if (act_vec() !== exp_vec()) begin
                n_err++; $display("FAIL toggle[%0d]: got %h want %h", pulses, act_vec(), exp_vec());
            end
        end
        n_cmp++;
        if (pulses != 16 || op_a[3:0] !== 4'h7) begin
            n_err++; $display("FAIL toggle_len: got %0d pulses lsn %h want 16 pulses lsn 7", pulses, op_a[3:0]);
        end
    endtask

    task automatic test_clear();
        step(1'b0, 1'b1, 4'h0, 4'h0, 1'b1);
        for (int i = 0; i < 11; i++) step(1'b1, 1'b0, 4'hE, 4'hD, 1'b1);
        n_cmp++;
        if (loading_b !== 1'b1 || nib_idx !== 3'd3) begin
            n_err++; $display("FAIL clear_setup: got lb=%b idx=%0d want lb=1 idx=3", loading_b, nib_idx);
        end
        step(1'b1, 1'b1, 4'h1, 4'h1, 1'b1);
        n_cmp++;
        if (act_vec() !== {32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 3'd0}) begin
            n_err++; $display("FAIL clear_prio: got %h want %h", act_vec(), {32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 3'd0});
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 4'h7, 4'h0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        n_cmp++;
        if (act_vec() !== exp_vec()) begin
            n_err++; $display("FAIL async_reset: got %h want %h", act_vec(), exp_vec());
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            step($urandom_range(0, 9) < 7, $urandom_range(0, 39) == 0,
                 4'($urandom), 4'($urandom), 1'($urandom));
            n_cmp++;
            if (act_vec() !== exp_vec()) begin
                n_err++; $display("FAIL random[%0d]: got %h want %h", i, act_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_full();
        test_done_reload();
        test_half();
        step(1'b0, 1'b1, 4'h0, 4'h0, 1'b1);
        test_mode_toggle();
        test_clear();
        test_async_reset();
        test_random();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
